sm83_alu_flags_stacked: RTL and testbench

Parametrised successor to the SM83 flag unit. It holds the Z/N/H/C flags plus the DAA half-carry and secondary carry. It adds a hardware save/restore stack of flag contexts, used for interrupt entry/exit and nested handlers, with full/empty status and sticky error reporting. It sits beside the ALU core and feeds flag outputs to the data bus and the condition logic.

---
 rtl/sm83_alu_flags_stacked_if.sv | 44 ++++
 rtl/sm83_alu_flags_stacked.sv | 143 ++++++++++++++
 tb/tb_sm83_alu_flags_stacked.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sm83_alu_flags_stacked_if.sv
// Bus-side signal bundle for the SM83 flag unit with context stack.
// The master side drives flag sources and controls; the slave side is the flag unit.
interface sm83_alu_flags_stacked_if #(
    parameter int WORD_SIZE   = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [WORD_SIZE-1:0] din;
    logic [WORD_SIZE-1:0] dout;
    logic flags_bus, flags_alu;
    logic zero_we, zero_loop;
    logic half_carry_we, half_carry_cpl, daa_carry_we;
    logic neg_we, neg_set, neg_clr;
    logic carry_we, sec_carry_we, sec_carry_sh, sec_carry_daa, sec_carry_sel, carry_set, carry_cpl;
    logic zero_in, carry_in, shift_out_in, daa_carry_in, sign_in;
    logic push, pop, clr_err;
    logic zero, half_carry, daa_carry, neg, carry, pri_carry;
    logic [DW-1:0] depth;
    logic full, empty;
    logic overflow, underflow, src_err;

    modport master (
        output din, flags_bus, flags_alu, zero_we, zero_loop,
               half_carry_we, half_carry_cpl, daa_carry_we,
               neg_we, neg_set, neg_clr,
               carry_we, sec_carry_we, sec_carry_sh, sec_carry_daa, sec_carry_sel, carry_set, carry_cpl,
               zero_in, carry_in, shift_out_in, daa_carry_in, sign_in,
               push, pop, clr_err,
        input  dout, zero, half_carry, daa_carry, neg, carry, pri_carry,
               depth, full, empty, overflow, underflow, src_err
    );

    modport slave (
        input  din, flags_bus, flags_alu, zero_we, zero_loop,
               half_carry_we, half_carry_cpl, daa_carry_we,
               neg_we, neg_set, neg_clr,
               carry_we, sec_carry_we, sec_carry_sh, sec_carry_daa, sec_carry_sel, carry_set, carry_cpl,
               zero_in, carry_in, shift_out_in, daa_carry_in, sign_in,
               push, pop, clr_err,
        output dout, zero, half_carry, daa_carry, neg, carry, pri_carry,
               depth, full, empty, overflow, underflow, src_err
    );
endinterface

// File: rtl/sm83_alu_flags_stacked.sv
// SM83 flag unit: Z/N/H/C plus DAA half-carry and secondary carry, with a
// save/restore stack of flag contexts for interrupt entry/exit and sticky errors.
module sm83_alu_flags_stacked #(
    parameter int WORD_SIZE   = 8,
    parameter int STACK_DEPTH = 4
) (
    input logic                    clk,
    input logic                    reset,
    sm83_alu_flags_stacked_if.slave bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic          r_zero, r_neg, r_half, r_pri_carry, r_sec_carry, r_daa_carry;
    logic [5:0]    r_stack [STACK_DEPTH];
    logic [DW-1:0] r_depth;
    logic          r_overflow, r_underflow, r_src_err;

    logic          w_any_we, w_src_ok;
    logic          w_z_src, w_n_src, w_h_src, w_c_src, w_sec_src;
    logic          w_full, w_empty;
    logic          w_do_push, w_do_pop, w_do_xchg, w_restore;
    logic          w_ovf_evt, w_udf_evt, w_src_evt;
    logic [AW-1:0] w_top_idx, w_push_idx;
    logic [5:0]    w_ctx, w_top;
    logic          w_zero_nxt, w_neg_nxt, w_half_nxt, w_pri_nxt, w_sec_nxt, w_daa_nxt;
    logic          w_carry_out, w_half_out;

    // Decode flag sources, stack operations and error events for this cycle
    always_comb begin
        w_any_we  = bus.zero_we | bus.half_carry_we | bus.daa_carry_we |
                    bus.neg_we | bus.carry_we | bus.sec_carry_we;
        w_src_ok  = bus.flags_bus ^ bus.flags_alu;
        w_z_src   = bus.flags_bus ? bus.din[WORD_SIZE-1] : bus.zero_in;
        w_n_src   = bus.flags_bus ? bus.din[WORD_SIZE-2] : bus.sign_in;
        w_h_src   = bus.flags_bus ? bus.din[WORD_SIZE-3] : bus.carry_in;
        w_c_src   = bus.flags_bus ? bus.din[WORD_SIZE-4] : bus.carry_in;
        case ({bus.sec_carry_daa, bus.sec_carry_sh})
            2'b00:   w_sec_src = bus.carry_in;
            2'b01:   w_sec_src = bus.shift_out_in;
            2'b10:   w_sec_src = bus.daa_carry_in;
            default: w_sec_src = 1'b0;
        endcase

        w_full     = (r_depth == DW'(STACK_DEPTH));
        w_empty    = (r_depth == '0);
        w_top_idx  = AW'(r_depth - 1'b1);
        w_push_idx = AW'(r_depth);
        w_ctx      = {r_zero, r_neg, r_half, r_pri_carry, r_sec_carry, r_daa_carry};
        w_top      = r_stack[w_top_idx];

        // push+pop on an empty stack degrades to a plain push
        w_do_xchg  = bus.push & bus.pop & ~w_empty;
        w_do_push  = bus.push & ~w_do_xchg & ~w_full;
        w_do_pop   = bus.pop & ~bus.push & ~w_empty;
        w_restore  = w_do_pop | w_do_xchg;
        w_ovf_evt  = bus.push & ~bus.pop & w_full;
        w_udf_evt  = bus.pop & ~bus.push & w_empty;
        w_src_evt  = w_any_we & ~w_src_ok;
    end

    // Next flag values: gated writes first, then a stack restore overrides them
    always_comb begin
        w_zero_nxt = r_zero;
        w_neg_nxt  = r_neg;
        w_half_nxt = r_half;
        w_pri_nxt  = r_pri_carry;
        w_sec_nxt  = r_sec_carry;
        w_daa_nxt  = r_daa_carry;
        if (w_src_ok) begin
            if (bus.zero_we)
                w_zero_nxt = bus.zero_loop ? (r_zero & w_z_src) : w_z_src;
            if (bus.neg_we)
                w_neg_nxt = bus.neg_clr ? 1'b0 : (bus.neg_set | w_n_src);
            if (bus.half_carry_we)
                w_half_nxt = w_h_src;
            if (bus.daa_carry_we)
                w_daa_nxt = w_h_src;
            if (bus.sec_carry_we)
                w_sec_nxt = w_sec_src;
            else if (bus.carry_we)
                w_pri_nxt = w_c_src;
        end
        if (w_restore)
            {w_zero_nxt, w_neg_nxt, w_half_nxt, w_pri_nxt, w_sec_nxt, w_daa_nxt} = w_top;
    end

    // Flag, stack, depth and sticky error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_half      <= 1'b0;
            r_pri_carry <= 1'b0;
            r_sec_carry <= 1'b0;
            r_daa_carry <= 1'b0;
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_src_err   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++)
                r_stack[i] <= '0;
        end else begin
            r_zero      <= w_zero_nxt;
            r_neg       <= w_neg_nxt;
            r_half      <= w_half_nxt;
            r_pri_carry <= w_pri_nxt;
            r_sec_carry <= w_sec_nxt;
            r_daa_carry <= w_daa_nxt;
            if (w_do_push) begin
                r_stack[w_push_idx] <= w_ctx;
                r_depth             <= r_depth + 1'b1;
            end else if (w_do_pop) begin
                r_depth <= r_depth - 1'b1;
            end
            if (w_do_xchg)
                r_stack[w_top_idx] <= w_ctx;
            r_overflow  <= (r_overflow  & ~bus.clr_err) | w_ovf_evt;
            r_underflow <= (r_underflow & ~bus.clr_err) | w_udf_evt;
            r_src_err   <= (r_src_err   & ~bus.clr_err) | w_src_evt;
        end
    end

    // Visible flags with complement/force modifiers and the bus image
    always_comb begin
        w_carry_out = ((bus.sec_carry_sel ? r_sec_carry : r_pri_carry) | bus.carry_set) ^ bus.carry_cpl;
        w_half_out  = r_half ^ bus.half_carry_cpl;
        bus.dout    = '0;
        bus.dout[WORD_SIZE-1:WORD_SIZE-4] = {r_zero, r_neg, w_half_out, w_carry_out};
        bus.zero       = r_zero;
        bus.neg        = r_neg;
        bus.half_carry = w_half_out;
        bus.daa_carry  = r_daa_carry;
        bus.carry      = w_carry_out;
        bus.pri_carry  = r_pri_carry;
        bus.depth      = r_depth;
        bus.full       = w_full;
        bus.empty      = w_empty;
        bus.overflow   = r_overflow;
        bus.underflow  = r_underflow;
        bus.src_err    = r_src_err;
    end
endmodule

// File: tb/tb_sm83_alu_flags_stacked.sv
// Directed vector bench for the stacked SM83 flag unit.
module tb_sm83_alu_flags_stacked;
    logic clk;
    logic reset;
    int   nChecks = 0;
    int   nFail   = 0;

    sm83_alu_flags_stacked_if #(.WORD_SIZE(8), .STACK_DEPTH(4)) ifc ();

    sm83_alu_flags_stacked #(.WORD_SIZE(8), .STACK_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    // src {bus,alu}; we {zero,neg,half,carry,daa,sec};
    // mods {loop,nset,nclr,sh,sdaa,sel,set,cpl,hcpl}; ai {zero_in,carry_in,shift_out_in,daa_carry_in,sign_in};
    // stk {push,pop,clr}; ecar {pri_carry,daa_carry,carry}; est {full,empty,overflow,underflow,src_err}
    typedef struct {
        string      name;
        logic [1:0] src;
        logic [7:0] din;
        logic [5:0] we;
        logic [8:0] mods;
        logic [4:0] ai;
        logic [2:0] stk;
        logic [7:0] edout;
        logic [2:0] ecar;
        logic [2:0] edep;
        logic [4:0] est;
    } vec_t;

    vec_t vecs[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string n, logic [1:0] src, logic [7:0] din, logic [5:0] we,
                                logic [8:0] mods, logic [4:0] ai, logic [2:0] stk,
                                logic [7:0] edout, logic [2:0] ecar, logic [2:0] edep, logic [4:0] est);
        vec_t v;
        v.name = n; v.src = src; v.din = din; v.we = we; v.mods = mods; v.ai = ai; v.stk = stk;
        v.edout = edout; v.ecar = ecar; v.edep = edep; v.est = est;
        return v;
    endfunction

    task automatic driveIdle();
        {ifc.flags_bus, ifc.flags_alu} = 2'b00;
        ifc.din = 8'h00;
        {ifc.zero_we, ifc.neg_we, ifc.half_carry_we, ifc.carry_we, ifc.daa_carry_we, ifc.sec_carry_we} = 6'b0;
        {ifc.zero_loop, ifc.neg_set, ifc.neg_clr, ifc.sec_carry_sh, ifc.sec_carry_daa,
         ifc.sec_carry_sel, ifc.carry_set, ifc.carry_cpl, ifc.half_carry_cpl} = 9'b0;
        {ifc.zero_in, ifc.carry_in, ifc.shift_out_in, ifc.daa_carry_in, ifc.sign_in} = 5'b0;
        {ifc.push, ifc.pop, ifc.clr_err} = 3'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        {ifc.flags_bus, ifc.flags_alu} = v.src;
        ifc.din = v.din;
        {ifc.zero_we, ifc.neg_we, ifc.half_carry_we, ifc.carry_we, ifc.daa_carry_we, ifc.sec_carry_we} = v.we;
        {ifc.zero_loop, ifc.neg_set, ifc.neg_clr, ifc.sec_carry_sh, ifc.sec_carry_daa,
         ifc.sec_carry_sel, ifc.carry_set, ifc.carry_cpl, ifc.half_carry_cpl} = v.mods;
        {ifc.zero_in, ifc.carry_in, ifc.shift_out_in, ifc.daa_carry_in, ifc.sign_in} = v.ai;
        {ifc.push, ifc.pop, ifc.clr_err} = v.stk;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string what, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
        end
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, ".dout"},   32'(ifc.dout), 32'(v.edout));
        checkOutput({v.name, ".carries"}, 32'({ifc.pri_carry, ifc.daa_carry, ifc.carry}), 32'(v.ecar));
        checkOutput({v.name, ".depth"},  32'(ifc.depth), 32'(v.edep));
        checkOutput({v.name, ".status"},
                    32'({ifc.full, ifc.empty, ifc.overflow, ifc.underflow, ifc.src_err}), 32'(v.est));
    endtask

    initial begin
        vecs.push_back(mk("bus_wr_B0",      2'b10, 8'hB0, 6'b111100, 9'b000000000, 5'b00000, 3'b000, 8'hB0, 3'b101, 3'd0, 5'b01000));
        vecs.push_back(mk("push_B0",        2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b100, 8'hB0, 3'b101, 3'd1, 5'b00000));
        vecs.push_back(mk("bus_wr_40",      2'b10, 8'h40, 6'b111100, 9'b000000000, 5'b00000, 3'b000, 8'h40, 3'b000, 3'd1, 5'b00000));
        vecs.push_back(mk("pop_over_wr",    2'b10, 8'h00, 6'b111100, 9'b000000000, 5'b00000, 3'b010, 8'hB0, 3'b101, 3'd0, 5'b01000));
        vecs.push_back(mk("alu_carry_0",    2'b01, 8'h00, 6'b000100, 9'b000000000, 5'b00000, 3'b000, 8'hA0, 3'b000, 3'd0, 5'b01000));
        vecs.push_back(mk("pop_empty_wr",   2'b01, 8'h00, 6'b000100, 9'b000000000, 5'b01000, 3'b010, 8'hB0, 3'b101, 3'd0, 5'b01010));
        vecs.push_back(mk("clr_udf",        2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b001, 8'hB0, 3'b101, 3'd0, 5'b01000));
        vecs.push_back(mk("src_both",       2'b11, 8'h00, 6'b100000, 9'b000000000, 5'b00000, 3'b000, 8'hB0, 3'b101, 3'd0, 5'b01001));
        vecs.push_back(mk("src_none_clr",   2'b00, 8'h00, 6'b100000, 9'b000000000, 5'b00000, 3'b001, 8'hB0, 3'b101, 3'd0, 5'b01001));
        vecs.push_back(mk("clr_src",        2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b001, 8'hB0, 3'b101, 3'd0, 5'b01000));
        vecs.push_back(mk("sec_blocks_pri", 2'b01, 8'h00, 6'b000101, 9'b000100000, 5'b00100, 3'b000, 8'hB0, 3'b101, 3'd0, 5'b01000));
        vecs.push_back(mk("carry_cpl",      2'b00, 8'h00, 6'b000000, 9'b000000010, 5'b00000, 3'b000, 8'hA0, 3'b100, 3'd0, 5'b01000));
        vecs.push_back(mk("sec_sel",        2'b00, 8'h00, 6'b000000, 9'b000001000, 5'b00000, 3'b000, 8'hB0, 3'b101, 3'd0, 5'b01000));
        vecs.push_back(mk("half_cpl",       2'b00, 8'h00, 6'b000000, 9'b000000001, 5'b00000, 3'b000, 8'h90, 3'b101, 3'd0, 5'b01000));
        vecs.push_back(mk("sec_mode11",     2'b01, 8'h00, 6'b000001, 9'b000111000, 5'b01110, 3'b000, 8'hA0, 3'b100, 3'd0, 5'b01000));
        vecs.push_back(mk("half_daa_wr",    2'b01, 8'h00, 6'b001010, 9'b000000000, 5'b01000, 3'b000, 8'hB0, 3'b111, 3'd0, 5'b01000));
        vecs.push_back(mk("sec_daa_src",    2'b01, 8'h00, 6'b000001, 9'b000011000, 5'b00010, 3'b000, 8'hB0, 3'b111, 3'd0, 5'b01000));
        vecs.push_back(mk("zero_loop_0",    2'b01, 8'h00, 6'b100000, 9'b100000000, 5'b00000, 3'b000, 8'h30, 3'b111, 3'd0, 5'b01000));
        vecs.push_back(mk("zero_loop_hold", 2'b01, 8'h00, 6'b100000, 9'b100000000, 5'b10000, 3'b000, 8'h30, 3'b111, 3'd0, 5'b01000));
        vecs.push_back(mk("zero_direct",    2'b01, 8'h00, 6'b100000, 9'b000000000, 5'b10000, 3'b000, 8'hB0, 3'b111, 3'd0, 5'b01000));
        vecs.push_back(mk("neg_set",        2'b01, 8'h00, 6'b010000, 9'b010000000, 5'b00000, 3'b000, 8'hF0, 3'b111, 3'd0, 5'b01000));
        vecs.push_back(mk("neg_clr",        2'b01, 8'h00, 6'b010000, 9'b001000000, 5'b00001, 3'b000, 8'hB0, 3'b111, 3'd0, 5'b01000));
        vecs.push_back(mk("neg_sign",       2'b01, 8'h00, 6'b010000, 9'b000000000, 5'b00001, 3'b000, 8'hF0, 3'b111, 3'd0, 5'b01000));
        vecs.push_back(mk("push_1",         2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b100, 8'hF0, 3'b111, 3'd1, 5'b00000));
        vecs.push_back(mk("push_2",         2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b100, 8'hF0, 3'b111, 3'd2, 5'b00000));
        vecs.push_back(mk("push_3",         2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b100, 8'hF0, 3'b111, 3'd3, 5'b00000));
        vecs.push_back(mk("push_4_full",    2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b100, 8'hF0, 3'b111, 3'd4, 5'b10000));
        vecs.push_back(mk("push_5_ovf",     2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b100, 8'hF0, 3'b111, 3'd4, 5'b10100));
        vecs.push_back(mk("clr_ovf",        2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b001, 8'hF0, 3'b111, 3'd4, 5'b10000));
        vecs.push_back(mk("pop_to_3",       2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b010, 8'hF0, 3'b111, 3'd3, 5'b00000));
        vecs.push_back(mk("pop_to_2",       2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b010, 8'hF0, 3'b111, 3'd2, 5'b00000));
        vecs.push_back(mk("pop_to_1",       2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b010, 8'hF0, 3'b111, 3'd1, 5'b00000));
        vecs.push_back(mk("zero_clear",     2'b01, 8'h00, 6'b100000, 9'b000000000, 5'b00000, 3'b000, 8'h70, 3'b111, 3'd1, 5'b00000));
        vecs.push_back(mk("xchg_1",         2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b110, 8'hF0, 3'b111, 3'd1, 5'b00000));
        vecs.push_back(mk("xchg_2",         2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b110, 8'h70, 3'b111, 3'd1, 5'b00000));
        vecs.push_back(mk("pop_last",       2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b010, 8'hF0, 3'b111, 3'd0, 5'b01000));
        vecs.push_back(mk("pushpop_empty",  2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b110, 8'hF0, 3'b111, 3'd1, 5'b00000));
        vecs.push_back(mk("push_with_wr",   2'b10, 8'h00, 6'b111100, 9'b000000000, 5'b00000, 3'b100, 8'h00, 3'b010, 3'd2, 5'b00000));
        vecs.push_back(mk("pop_prewrite",   2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b010, 8'hF0, 3'b111, 3'd1, 5'b00000));

        driveIdle();
        reset = 1'b1;
        #1;
        checkOutput("reset.dout",   32'(ifc.dout), 32'h00);
        checkOutput("reset.depth",  32'(ifc.depth), 32'd0);
        checkOutput("reset.status", 32'({ifc.full, ifc.empty, ifc.overflow, ifc.underflow, ifc.src_err}), 32'b01000);
        checkOutput("reset.carries", 32'({ifc.pri_carry, ifc.daa_carry, ifc.carry}), 32'b000);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkVector(vecs[i]);
        end

        // Asynchronous reset asserted between edges while a push is pending
        @(negedge clk);
        driveIdle();
        ifc.push = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_mid.depth", 32'(ifc.depth), 32'd0);
        checkOutput("rst_mid.empty", 32'(ifc.empty), 32'd1);
        checkOutput("rst_mid.dout",  32'(ifc.dout), 32'h00);
        @(posedge clk);
        #1;
        checkOutput("rst_hold.depth", 32'(ifc.depth), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ifc.push = 1'b0;
        applyStimulus(mk("push_after_rst", 2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b100,
                         8'h00, 3'b000, 3'd1, 5'b00000));
        checkVector(mk("push_after_rst", 2'b00, 8'h00, 6'b000000, 9'b000000000, 5'b00000, 3'b100,
                       8'h00, 3'b000, 3'd1, 5'b00000));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
